// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port unified memory between the instruction-fetch stage
// (read-only) and the MEM stage (loads/stores). Only one access is in flight
// at a time. A request seen in IDLE is latched into the memory port registers,
// presented with a req/ready handshake, and completed with a one-cycle done
// pulse to the winning requester. A watchdog aborts an access that waits too
// long and flags it with bus_err.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_if_req/i_if_addr    fetch request and address (held until o_if_done)
//   o_if_rdata/o_if_done  fetched word and its completion pulse
//   o_if_stall            fetch pending and not yet done
//   i_d_rd/i_d_wr         load / store request (never both set)
//   i_d_addr/i_d_wdata    data address / store data
//   i_d_be                store byte enables
//   o_d_rdata/o_d_done    load data and data completion pulse
//   o_d_stall             data access pending and not yet done
//   o_mem_req/o_mem_we    memory request (held until ready) and write flag
//   o_mem_addr/wdata/be   latched access attributes (be all ones on reads)
//   i_mem_rdata           memory read data, valid with i_mem_ready
//   i_mem_ready           memory accepts/completes the access this cycle
//   o_bus_err             pulse alongside the done of a timed-out access
// -----------------------------------------------------------------------------

// Protocol properties kept apart from the design logic.
module unified_mem_arbiter_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_if_done,
    input logic i_d_done,
    input logic i_bus_err,
    input logic i_mem_req
);

    // Only one access is ever in flight, so the two done pulses cannot overlap.
    a_done_exclusive: assert property (@(posedge i_clk) disable iff (i_reset)
        !(i_if_done && i_d_done));

    // An error is only ever reported together with the completion it belongs to.
    a_err_with_done: assert property (@(posedge i_clk) disable iff (i_reset)
        i_bus_err |-> (i_if_done || i_d_done));

    // The memory request is always dropped by the time completion is reported.
    a_req_low_at_done: assert property (@(posedge i_clk) disable iff (i_reset)
        (i_if_done || i_d_done) |-> !i_mem_req);

    // Done is a single-cycle pulse.
    a_done_single: assert property (@(posedge i_clk) disable iff (i_reset)
        (i_if_done || i_d_done) |=> !(i_if_done || i_d_done));

endmodule

module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic [DATA_W-1:0]     o_if_rdata,
    output logic                  o_if_done,
    output logic                  o_if_stall,
    input  logic                  i_d_rd,
    input  logic                  i_d_wr,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_be,
    output logic [DATA_W-1:0]     o_d_rdata,
    output logic                  o_d_done,
    output logic                  o_d_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_be,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    input  logic                  i_mem_ready,
    output logic                  o_bus_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT);

    // Counter value at which a still-unanswered access is abandoned; the
    // counter is 0 in the first mem_req cycle, so this gives TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last_d;      // 1: last grant went to data, 0: fetch
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_done;
    logic                r_d_done;
    logic                r_bus_err;

    logic                w_d_pend;
    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_timeout;

    assign w_d_pend  = i_d_rd | i_d_wr;
    assign w_timeout = (r_wait_cnt == CNT_LAST) & ~i_mem_ready;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (w_d_pend && i_if_req) begin
            w_grant_d = ~r_last_d;
            w_grant_i = r_last_d;
        end else begin
            w_grant_d = w_d_pend;
            w_grant_i = i_if_req;
        end
    end

    // Access sequencer: grant in IDLE, handshake in BUSY, one-cycle report in RESP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_last_d    <= 1'b0;
            r_wait_cnt  <= {CNT_W{1'b0}};
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_be    <= {BE_W{1'b1}};
            r_if_rdata  <= {DATA_W{1'b0}};
            r_d_rdata   <= {DATA_W{1'b0}};
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_if_done <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_bus_err <= 1'b0;
                    if (w_grant_d) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_d_wr;
                        r_mem_addr  <= i_d_addr;
                        r_mem_wdata <= i_d_wdata;
                        // Loads always fetch the whole word.
                        r_mem_be    <= i_d_wr ? i_d_be : {BE_W{1'b1}};
                        r_wait_cnt  <= {CNT_W{1'b0}};
                        r_last_d    <= 1'b1;
                        r_state     <= ST_BUSY_D;
                    end else if (w_grant_i) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= {DATA_W{1'b0}};
                        r_mem_be    <= {BE_W{1'b1}};
                        r_wait_cnt  <= {CNT_W{1'b0}};
                        r_last_d    <= 1'b0;
                        r_state     <= ST_BUSY_I;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end

                ST_BUSY_I, ST_BUSY_D: begin
                    if (i_mem_ready) begin
                        // Ready on the last allowed cycle still counts as success.
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RESP;
                        if (r_state == ST_BUSY_D) begin
                            r_d_done <= 1'b1;
                            if (!r_mem_we) begin
                                r_d_rdata <= i_mem_rdata;
                            end else begin
                                r_d_rdata <= r_d_rdata;
                            end
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= ST_RESP;
                        if (r_state == ST_BUSY_D) begin
                            r_d_done  <= 1'b1;
                            r_d_rdata <= {DATA_W{1'b0}};
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= {DATA_W{1'b0}};
                        end
                    end else begin
                        // Saturating: the counter never wraps back to zero.
                        if (r_wait_cnt != CNT_SAT) begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end else begin
                            r_wait_cnt <= r_wait_cnt;
                        end
                    end
                end

                ST_RESP: begin
                    // No grant here, so a requester can drop or change its
                    // request before it could be served again.
                    r_if_done <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    r_mem_req <= 1'b0;
                    r_if_done <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_if_stall  = i_if_req & ~r_if_done;
    assign o_d_stall   = w_d_pend & ~r_d_done;

    assign o_if_rdata  = r_if_rdata;
    assign o_if_done   = r_if_done;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_done    = r_d_done;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_be    = r_mem_be;
    assign o_bus_err   = r_bus_err;

    unified_mem_arbiter_chk u_chk (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_if_done (r_if_done),
        .i_d_done  (r_d_done),
        .i_bus_err (r_bus_err),
        .i_mem_req (r_mem_req)
    );

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for unified_mem_arbiter. The reference model describes each access as
// a time window: granted at cycle g, mem_req for cycles g+1..g+L with
// L = min(k, TIMEOUT) where k is the planned ready cycle, done at g+L+1, and
// the arbiter free again from g+L+2. Directed scenarios come first, followed
// by randomized traffic.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int T  = 16;

    logic           clk;
    logic           reset;
    logic           if_req;
    logic [AW-1:0]  if_addr;
    logic [DW-1:0]  if_rdata;
    logic           if_done;
    logic           if_stall;
    logic           d_rd;
    logic           d_wr;
    logic [AW-1:0]  d_addr;
    logic [DW-1:0]  d_wdata;
    logic [BW-1:0]  d_be;
    logic [DW-1:0]  d_rdata;
    logic           d_done;
    logic           d_stall;
    logic           mem_req;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [BW-1:0]  mem_be;
    logic [DW-1:0]  mem_rdata;
    logic           mem_ready;
    logic           bus_err;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_done   (if_done),
        .o_if_stall  (if_stall),
        .i_d_rd      (d_rd),
        .i_d_wr      (d_wr),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .i_d_be      (d_be),
        .o_d_rdata   (d_rdata),
        .o_d_done    (d_done),
        .o_d_stall   (d_stall),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_be    (mem_be),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .o_bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;

    // Requested stimulus for the next cycle.
    logic           s_reset = 1'b1;
    logic           s_if_req = 1'b0;
    logic [AW-1:0]  s_if_addr = '0;
    logic           s_d_rd = 1'b0;
    logic           s_d_wr = 1'b0;
    logic [AW-1:0]  s_d_addr = '0;
    logic [DW-1:0]  s_d_wdata = '0;
    logic [BW-1:0]  s_d_be = '0;
    int             force_k = 0;
    bit             fixed_rdata_en = 1'b0;
    logic [DW-1:0]  fixed_rdata = '0;

    // Reference model: the current access window and expected outputs.
    bit             a_act = 1'b0;
    int             a_g = 0;
    int             a_k = 0;
    int             a_len = 0;
    bit             a_err = 1'b0;
    bit             a_d = 1'b0;
    bit             a_we = 1'b0;
    logic [AW-1:0]  a_addr = '0;
    logic [DW-1:0]  a_wdata = '0;
    logic [BW-1:0]  a_be = '0;
    logic [DW-1:0]  a_cap = '0;
    int             free_at = 0;
    bit             last_d = 1'b0;
    bit             rst_pending = 1'b0;
    logic [DW-1:0]  e_if_rdata = '0;
    logic [DW-1:0]  e_d_rdata = '0;
    bit             e_if_done = 1'b0;
    bit             e_d_done = 1'b0;
    bit             e_err = 1'b0;
    bit             e_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    // Planned ready delay for a new access; k > T means the memory never answers.
    function automatic int plan_k();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0, 1, 2, 3, 9: return int'($urandom_range(1, 3));
            5, 6:          return int'($urandom_range(4, T - 1));
            7:             return T;
            8:             return T + 1;
            default:       return 1;
        endcase
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return $urandom & 32'h0000_FFFC;
    endfunction

    // One clock cycle: apply stimulus, advance the model, compare outputs.
    task automatic tick();
        logic [DW-1:0] rd;
        bit dp;
        bit ip;
        int dcyc;
        reset   = s_reset;
        if_req  = s_if_req;
        if_addr = s_if_addr;
        d_rd    = s_d_rd;
        d_wr    = s_d_wr;
        d_addr  = s_d_addr;
        d_wdata = s_d_wdata;
        d_be    = s_d_be;
        rd = fixed_rdata_en ? fixed_rdata : $urandom;
        mem_rdata = rd;
        if (a_act && (n >= a_g + 1) && (n <= a_g + a_len))
            mem_ready = (a_k <= T) && (n == a_g + a_k);
        else
            mem_ready = 1'($urandom_range(0, 1));
        rst_pending = s_reset;
        if (!s_reset) begin
            if (a_act && (a_k <= T) && (n == a_g + a_k)) a_cap = rd;
            dp = s_d_rd | s_d_wr;
            ip = s_if_req;
            if ((n >= free_at) && (dp || ip)) begin
                a_d     = dp && (!ip || !last_d);
                last_d  = a_d;
                a_act   = 1'b1;
                a_g     = n;
                a_k     = (force_k > 0) ? force_k : plan_k();
                a_len   = (a_k <= T) ? a_k : T;
                a_err   = (a_k > T);
                a_we    = a_d && s_d_wr;
                a_addr  = a_d ? s_d_addr : s_if_addr;
                a_wdata = s_d_wdata;
                a_be    = a_we ? s_d_be : {BW{1'b1}};
                free_at = n + a_len + 2;
            end
        end
        #1;
        chk("if_stall", 32'(if_stall), 32'(s_if_req & ~e_if_done));
        chk("d_stall", 32'(d_stall), 32'((s_d_rd | s_d_wr) & ~e_d_done));
        @(posedge clk);
        #1;
        n++;
        if (rst_pending) begin
            a_act = 1'b0;
            free_at = n;
            last_d = 1'b0;
            e_if_rdata = '0;
            e_d_rdata = '0;
            e_if_done = 1'b0;
            e_d_done = 1'b0;
            e_err = 1'b0;
            e_req = 1'b0;
            chk("rst_mem_be", 32'(mem_be), 32'hF);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
        end else begin
            dcyc = a_g + a_len + 1;
            e_req     = a_act && (n >= a_g + 1) && (n <= a_g + a_len);
            e_if_done = a_act && !a_d && (n == dcyc);
            e_d_done  = a_act && a_d && (n == dcyc);
            e_err     = a_act && a_err && (n == dcyc);
            if (a_act && (n == dcyc)) begin
                if (a_err) begin
                    if (a_d) e_d_rdata = '0; else e_if_rdata = '0;
                end else if (!a_we) begin
                    if (a_d) e_d_rdata = a_cap; else e_if_rdata = a_cap;
                end
            end
        end
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("if_done", 32'(if_done), 32'(e_if_done));
        chk("d_done", 32'(d_done), 32'(e_d_done));
        chk("bus_err", 32'(bus_err), 32'(e_err));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        if (e_req) begin
            chk("mem_we", 32'(mem_we), 32'(a_we));
            chk("mem_addr", mem_addr, a_addr);
            chk("mem_be", 32'(mem_be), 32'(a_be));
            if (a_we) chk("mem_wdata", mem_wdata, a_wdata);
        end
    endtask

    initial begin
        int req_cycles;
        int done_cnt;
        int err_cnt;
        bit prev_req;
        bit d_second;
        logic [AW-1:0] rise_addr[$];
        int rise_cyc[$];

        // Reset state.
        s_reset = 1'b1;
        tick();
        tick();
        chk("reset_req", 32'(mem_req), 32'h0);
        chk("reset_be", 32'(mem_be), 32'hF);
        chk("reset_if_rdata", if_rdata, 32'h0);
        chk("reset_d_done", 32'(d_done), 32'h0);
        chk("reset_bus_err", 32'(bus_err), 32'h0);
        s_reset = 1'b0;

        // Store with ready three cycles after mem_req rises.
        s_d_wr = 1'b1; s_d_addr = 32'h100; s_d_wdata = 32'hDEADBEEF; s_d_be = 4'b0011;
        force_k = 4;
        req_cycles = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                chk("wr_we", 32'(mem_we), 32'h1);
                chk("wr_be", 32'(mem_be), 32'h3);
                chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
            end
            if (mem_req === 1'b1) req_cycles++;
            if (d_done === 1'b1) done_cnt++;
            if (e_d_done) s_d_wr = 1'b0;
        end
        chk("wr_req_cycles", 32'(req_cycles), 32'd4);
        chk("wr_done_count", 32'(done_cnt), 32'd1);
        chk("wr_rdata_kept", d_rdata, 32'h0);

        // Zero-wait fetch.
        s_if_req = 1'b1; s_if_addr = 32'h40;
        force_k = 1; fixed_rdata_en = 1'b1; fixed_rdata = 32'h13;
        tick();
        chk("fetch_req", 32'(mem_req), 32'h1);
        chk("fetch_addr", mem_addr, 32'h40);
        chk("fetch_we", 32'(mem_we), 32'h0);
        chk("fetch_stall_c1", 32'(if_stall), 32'h1);
        tick();
        chk("fetch_done", 32'(if_done), 32'h1);
        chk("fetch_rdata", if_rdata, 32'h13);
        chk("fetch_stall_c2", 32'(if_stall), 32'h0);
        s_if_req = 1'b0;
        tick();
        chk("fetch_done_clr", 32'(if_done), 32'h0);

        // Round robin: tie with last grant = fetch, then a second tie.
        fixed_rdata = 32'hA5A5_0001;
        s_if_req = 1'b1; s_if_addr = 32'h200;
        s_d_rd = 1'b1; s_d_addr = 32'h300;
        d_second = 1'b0; prev_req = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (mem_req === 1'b1 && !prev_req) begin
                rise_addr.push_back(mem_addr);
                rise_cyc.push_back(n);
            end
            prev_req = (mem_req === 1'b1);
            if (e_if_done) s_if_req = 1'b0;
            if (e_d_done) begin
                if (!d_second) begin
                    s_d_addr = 32'h304;
                    d_second = 1'b1;
                end else begin
                    s_d_rd = 1'b0;
                end
            end
        end
        chk("rr_grants", 32'(rise_addr.size()), 32'd3);
        if (rise_addr.size() == 3) begin
            chk("rr_first", rise_addr[0], 32'h300);
            chk("rr_second", rise_addr[1], 32'h200);
            chk("rr_third", rise_addr[2], 32'h304);
            chk("rr_gap", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
        end

        // Memory never answers: watchdog abort.
        s_d_rd = 1'b1; s_d_addr = 32'h400;
        force_k = T + 1;
        req_cycles = 0; done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (mem_req === 1'b1) req_cycles++;
            if (d_done === 1'b1) done_cnt++;
            if (bus_err === 1'b1) err_cnt++;
            if (e_d_done) begin
                chk("to_err_with_done", 32'(bus_err), 32'h1);
                chk("to_rdata", d_rdata, 32'h0);
                s_d_rd = 1'b0;
            end
        end
        chk("to_req_cycles", 32'(req_cycles), 32'd16);
        chk("to_done_count", 32'(done_cnt), 32'd1);
        chk("to_err_count", 32'(err_cnt), 32'd1);

        // Reset in the second busy cycle of a fetch.
        s_if_req = 1'b1; s_if_addr = 32'h500;
        force_k = 10;
        tick();
        tick();
        s_reset = 1'b1;
        tick();
        chk("rst_busy_req", 32'(mem_req), 32'h0);
        chk("rst_busy_done", 32'(if_done), 32'h0);
        chk("rst_busy_stall", 32'(if_stall), 32'h1);
        s_reset = 1'b0;
        tick();
        chk("regrant_req", 32'(mem_req), 32'h1);
        chk("regrant_addr", mem_addr, 32'h500);
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (if_done === 1'b1) done_cnt++;
            if (e_if_done) s_if_req = 1'b0;
        end
        chk("regrant_done_count", 32'(done_cnt), 32'd1);

        // Request held through RESP: no regrant until the following IDLE.
        s_if_req = 1'b1; s_if_addr = 32'h600;
        force_k = 1;
        tick();
        chk("hold_req1", 32'(mem_req), 32'h1);
        tick();
        chk("hold_done1", 32'(if_done), 32'h1);
        tick();
        chk("hold_resp_no_grant", 32'(mem_req), 32'h0);
        tick();
        chk("hold_req2", 32'(mem_req), 32'h1);
        chk("hold_addr2", mem_addr, 32'h600);
        s_if_req = 1'b0;
        tick();
        chk("hold_done2", 32'(if_done), 32'h1);
        tick();

        // Randomized traffic.
        force_k = 0;
        fixed_rdata_en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (s_if_req) begin
                if (e_if_done) begin
                    if ($urandom_range(0, 1) == 0) s_if_req = 1'b0;
                    else s_if_addr = rnd_addr();
                end else if (a_act && !a_d && (n >= a_g + 1) && (n <= a_g + a_len)
                             && ($urandom_range(0, 7) == 0)) begin
                    s_if_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                s_if_req = 1'b1;
                s_if_addr = rnd_addr();
            end
            if (s_d_rd || s_d_wr) begin
                if (e_d_done) begin
                    s_d_rd = 1'b0;
                    s_d_wr = 1'b0;
                end else if (a_act && a_d && (n >= a_g + 1) && (n <= a_g + a_len)
                             && ($urandom_range(0, 7) == 0)) begin
                    s_d_rd = 1'b0;
                    s_d_wr = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                s_d_wr = 1'($urandom_range(0, 1));
                s_d_rd = ~s_d_wr;
                s_d_addr = rnd_addr();
                s_d_wdata = $urandom;
                s_d_be = 4'($urandom_range(0, 15));
            end
            s_reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
